// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS freq_ctrl word from f_start to f_stop in f_step increments,
// holding each word dwell+1 clocks, as a single up-sweep or a continuous triangle.
module dds_sweep_ctrl #(
    parameter int FW = 8,
    parameter int DW = 16
) (
    input  logic          clk_100kHz,
    input  logic          rst_,
    input  logic          start,
    input  logic          abort,
    input  logic          mode,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    output logic [FW-1:0] freq_ctrl,
    output logic          busy,
    output logic          sweep_dn,
    output logic          done,
    output logic          cfg_err
);
    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN} state_t;
    state_t        state, state_n;
    logic [FW-1:0] freq_n, start_r, stop_r, step_r, up_w, dn_w;
    logic [DW-1:0] cnt, cnt_n, dwell_r;
    logic          mode_r, done_n, cfg_err_n, load;
    logic [FW:0]   up_sum, dn_diff;
    // One bit wider than the word so the step can neither wrap past 2^FW nor below 0
    always_comb begin
        up_sum  = {1'b0, freq_ctrl} + {1'b0, step_r};
        dn_diff = {1'b0, freq_ctrl} - {1'b0, step_r};
        up_w    = (up_sum > {1'b0, stop_r}) ? stop_r : up_sum[FW-1:0];
        dn_w    = (dn_diff[FW] || dn_diff[FW-1:0] < start_r) ? start_r : dn_diff[FW-1:0];
    end
    always_comb begin
        state_n   = state;
        freq_n    = freq_ctrl;
        cnt_n     = cnt;
        done_n    = 1'b0;
        cfg_err_n = 1'b0;
        load      = 1'b0;
        if (abort) begin
            state_n = IDLE;
            freq_n  = '0;
        end else if (state == IDLE) begin
            if (start && (f_step == '0 || f_start > f_stop))
                cfg_err_n = 1'b1;
            else if (start) begin
                load    = 1'b1;
                freq_n  = f_start;
                cnt_n   = dwell;
                state_n = RUN_UP;
            end
        end else if (cnt != '0)
            cnt_n = cnt - 1'b1;
        else begin
            cnt_n = dwell_r;
            // A direction turn applies the opposite leg's rule in the same cycle
            if (state == RUN_UP) begin
                if (freq_ctrl != stop_r)
                    freq_n = up_w;
                else if (!mode_r) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = RUN_DN;
                    freq_n  = dn_w;
                end
            end else if (freq_ctrl != start_r)
                freq_n = dn_w;
            else begin
                state_n = RUN_UP;
                freq_n  = up_w;
            end
        end
    end
    always_ff @(posedge clk_100kHz or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            freq_ctrl <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            sweep_dn  <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            mode_r    <= 1'b0;
            start_r   <= '0;
            stop_r    <= '0;
            step_r    <= '0;
            dwell_r   <= '0;
        end else begin
            state     <= state_n;
            freq_ctrl <= freq_n;
            cnt       <= cnt_n;
            busy      <= state_n != IDLE;
            sweep_dn  <= state_n == RUN_DN;
            done      <= done_n;
            cfg_err   <= cfg_err_n;
            if (load) begin
                mode_r  <= mode;
                start_r <= f_start;
                stop_r  <= f_stop;
                step_r  <= f_step;
                dwell_r <= dwell;
            end
        end
    end
endmodule
